// File: rtl/clock_mode_sequencer.sv
// Sequences PLL option and CPU turbo changes for clock_generator, freezing cpuclk
// (clk_hold) before and after each switch and waiting for PLL SRDY with a timeout.
module clock_mode_sequencer #(
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned PLL_MIN_WAIT = 16,
    parameter int unsigned PLL_TIMEOUT  = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_pll,
    input  logic [1:0] req_turbo,
    input  logic       pll_srdy,
    output logic [2:0] pll_option,
    output logic [1:0] turbo_enable,
    output logic       clk_hold,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        PRE_HOLD,
        SWITCH,
        PLL_WAIT,
        POST_HOLD,
        DONE
    } state_t;

    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] MIN_WAIT     = 16'(PLL_MIN_WAIT);
    localparam logic [15:0] TIMEOUT_LAST = 16'(PLL_TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic [2:0]  pll_lat;
    logic [1:0]  turbo_lat;

    // Saturating increment so no state can ever wrap the counter.
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    // NOTE: every register here uses <= so all branches see pre-edge values of state/cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 16'd0;
            pll_lat      <= 3'd0;
            turbo_lat    <= 2'd0;
            pll_option   <= 3'd0;
            turbo_enable <= 2'd0;
            clk_hold     <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        pll_lat     <= req_pll;
                        turbo_lat   <= req_turbo;
                        timeout_err <= 1'b0;
                        cnt         <= 16'd0;
                        if (req_pll == pll_option && req_turbo == turbo_enable) begin
                            state <= DONE;
                        end else begin
                            state    <= PRE_HOLD;
                            clk_hold <= 1'b1;
                        end
                    end
                end
                PRE_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= SWITCH;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                SWITCH: begin
                    pll_option   <= pll_lat;
                    turbo_enable <= turbo_lat;
                    cnt          <= 16'd0;
                    state        <= (pll_lat != pll_option) ? PLL_WAIT : POST_HOLD;
                end
                PLL_WAIT: begin
                    // A valid srdy wins over the timeout on the same cycle.
                    if (pll_srdy && cnt >= MIN_WAIT) begin
                        state <= POST_HOLD;
                        cnt   <= 16'd0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= POST_HOLD;
                        cnt         <= 16'd0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                POST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= DONE;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DONE: begin
                    clk_hold <= 1'b0;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign req_ready = ~busy & ~rst;

endmodule

// File: tb/tb_clock_mode_sequencer.sv
// Directed bench for clock_mode_sequencer: turbo-only, PLL with early srdy, PLL timeout,
// NOP request, request held while busy, and reset in the middle of PLL_WAIT.
module tb_clock_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_pll;
    logic [1:0] req_turbo;
    logic       pll_srdy;
    logic [2:0] pll_option;
    logic [1:0] turbo_enable;
    logic       clk_hold;
    logic       busy;
    logic       done;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    clock_mode_sequencer #(
        .HOLD_CYCLES (4),
        .PLL_MIN_WAIT(16),
        .PLL_TIMEOUT (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pll     (req_pll),
        .req_turbo   (req_turbo),
        .pll_srdy    (pll_srdy),
        .pll_option  (pll_option),
        .turbo_enable(turbo_enable),
        .clk_hold    (clk_hold),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_pll   = 3'd0;
        req_turbo = 2'd0;
        pll_srdy  = 1'b0;
        tick();
        tick();
        check("rst_ready", req_ready, 0);
        check("rst_pll", pll_option, 0);
        check("rst_turbo", turbo_enable, 0);
        check("rst_hold", clk_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_terr", timeout_err, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1);
        tick();

        // T2: turbo-only 00 -> 10, accept at t0
        req_valid = 1'b1;
        req_pll   = 3'd0;
        req_turbo = 2'b10;
        check("t2_ready_t0", req_ready, 1);
        tick();
        req_valid = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            check($sformatf("t2_hold_t%0d", t), clk_hold, 1);
            check($sformatf("t2_done_t%0d", t), done, 0);
            if (t == 5) check("t2_turbo_t5", turbo_enable, 2'b00);
            if (t == 6) check("t2_turbo_t6", turbo_enable, 2'b10);
            tick();
        end
        check("t2_done_t11", done, 1);
        check("t2_hold_t11", clk_hold, 0);
        check("t2_pll_t11", pll_option, 0);
        check("t2_busy_t11", busy, 0);
        tick();
        check("t2_done_t12", done, 0);

        // T3: pll 000 -> 011, early srdy at cnt=5 ignored, srdy at cnt=20 accepted
        req_valid = 1'b1;
        req_pll   = 3'd3;
        req_turbo = 2'b10;
        tick();
        req_valid = 1'b0;
        for (int t = 1; t <= 31; t++) begin
            pll_srdy = (t == 11 || t == 26);
            if (t == 5)  check("t3_pll_t5", pll_option, 0);
            if (t == 6)  check("t3_pll_t6", pll_option, 3);
            if (t == 17) check("t3_done_t17", done, 0);
            if (t == 31) begin
                check("t3_hold_t31", clk_hold, 1);
                check("t3_done_t31", done, 0);
            end
            tick();
        end
        pll_srdy = 1'b0;
        check("t3_done_t32", done, 1);
        check("t3_hold_t32", clk_hold, 0);
        check("t3_terr", timeout_err, 0);
        tick();

        // T4: pll 011 -> 101 with no srdy; PLL_WAIT runs t6..t105
        req_valid = 1'b1;
        req_pll   = 3'd5;
        req_turbo = 2'b10;
        tick();
        req_valid = 1'b0;
        for (int t = 1; t <= 110; t++) begin
            if (t == 105) check("t4_terr_t105", timeout_err, 0);
            if (t == 106) check("t4_terr_t106", timeout_err, 1);
            if (t == 106) check("t4_hold_t106", clk_hold, 1);
            if (t == 110) check("t4_done_t110", done, 0);
            tick();
        end
        check("t4_done_t111", done, 1);
        check("t4_terr_t111", timeout_err, 1);
        check("t4_pll_t111", pll_option, 5);

        // T5: NOP request equal to current outputs; also clears timeout_err
        req_valid = 1'b1;
        req_pll   = 3'd5;
        req_turbo = 2'b10;
        tick();
        req_valid = 1'b0;
        check("t5_terr_cleared", timeout_err, 0);
        check("t5_busy_t1", busy, 1);
        check("t5_hold_t1", clk_hold, 0);
        check("t5_done_t1", done, 0);
        tick();
        check("t5_done_t2", done, 1);
        check("t5_hold_t2", clk_hold, 0);
        check("t5_busy_t2", busy, 0);
        tick();
        check("t5_done_t3", done, 0);

        // T6: request A (turbo 01) then values change to B (turbo 00) while valid held
        req_valid = 1'b1;
        req_pll   = 3'd5;
        req_turbo = 2'b01;
        tick();
        req_turbo = 2'b00;
        for (int t = 1; t <= 10; t++) begin
            if (t == 6) check("t6_turbo_a", turbo_enable, 2'b01);
            if (t == 3) check("t6_ready_busy", req_ready, 0);
            tick();
        end
        check("t6_done_a", done, 1);
        check("t6_ready_t11", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("t6_busy_b", busy, 1);
        check("t6_hold_b", clk_hold, 1);
        for (int t = 12; t <= 21; t++) begin
            if (t == 17) check("t6_turbo_b", turbo_enable, 2'b00);
            tick();
        end
        check("t6_done_b", done, 1);
        tick();
        tick();
        check("t6_idle", busy, 0);

        // T1: reset held 3 cycles in the middle of PLL_WAIT
        req_valid = 1'b1;
        req_pll   = 3'd1;
        req_turbo = 2'b00;
        tick();
        req_valid = 1'b0;
        for (int t = 1; t <= 9; t++) tick();
        check("t1_busy_pre", busy, 1);
        check("t1_pll_pre", pll_option, 1);
        rst = 1'b1;
        #1;
        check("t1_ready_in_rst", req_ready, 0);
        tick();
        check("t1_pll", pll_option, 0);
        check("t1_turbo", turbo_enable, 0);
        check("t1_hold", clk_hold, 0);
        check("t1_busy", busy, 0);
        check("t1_done", done, 0);
        check("t1_terr", timeout_err, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("t1_ready_after", req_ready, 1);
        for (int t = 0; t < 3; t++) begin
            check($sformatf("t1_no_done_%0d", t), done, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
